// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/branch controls in, instruction memory
// port, and the IF/ID register contents out to decode.
interface fetch_stage_if;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic [31:0] imem_address;
    logic [31:0] imem_data;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_valid;
    logic [31:0] fetch_count;

    modport master (
        input  freeze,
        input  branch_taken,
        input  branch_address,
        input  imem_data,
        output imem_address,
        output if_pc,
        output if_instruction,
        output if_valid,
        output fetch_count
    );

    modport slave (
        output freeze,
        output branch_taken,
        output branch_address,
        output imem_data,
        input  imem_address,
        input  if_pc,
        input  if_instruction,
        input  if_valid,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads a zero-latency instruction
// memory and loads the IF/ID register, with freeze and branch flush.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input logic          clk,
    input logic          rst,
    fetch_stage_if.master fif
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_NOP = '{
        pc:          32'h0,
        instruction: 32'h0,
        valid:       1'b0
    };

    logic [31:0] pc;
    logic [31:0] pc_seq;
    logic [31:0] pc_target;
    logic [31:0] count;
    if_id_t      if_id;

    // Exactly one of these is set each cycle; branch overrides freeze.
    logic mode_branch;
    logic mode_hold;
    logic mode_run;

    assign mode_branch = fif.branch_taken;
    assign mode_hold   = !fif.branch_taken && fif.freeze;
    assign mode_run    = !fif.branch_taken && !fif.freeze;

    assign pc_seq    = pc + 32'(PC_STEP);
    assign pc_target = {fif.branch_address[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc    <= RESET_PC;
            if_id <= IF_ID_NOP;
            count <= 32'h0;
        end else begin
            unique case (1'b1)
                mode_branch: begin
                    pc    <= pc_target;
                    if_id <= IF_ID_NOP;
                end
                mode_hold: begin
                    pc    <= pc;
                    if_id <= if_id;
                end
                mode_run: begin
                    pc                <= pc_seq;
                    if_id.pc          <= pc_seq;
                    if_id.instruction <= fif.imem_data;
                    if_id.valid       <= 1'b1;
                    count             <= count + 32'h1;
                end
                default: begin
                    pc    <= pc;
                    if_id <= if_id;
                end
            endcase
        end
    end

    assign fif.imem_address   = pc;
    assign fif.if_pc          = if_id.pc;
    assign fif.if_instruction = if_id.instruction;
    assign fif.if_valid       = if_id.valid;
    assign fif.fetch_count    = count;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async reset cases,
// and random freeze/branch traffic against a behavioural model.
module tb_fetch_stage;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fetch_stage_if fif ();

    fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fif(fif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'hE3A0_0014;
        if (a == 32'h4) return 32'hE3A0_1A01;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    assign fif.imem_data = memf(fif.imem_address);

    // Reference state, derived from the fetch rules directly.
    logic [31:0] m_pc, m_ifpc, m_instr, m_cnt;
    logic        m_valid;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] p,
                           input logic [31:0] ip, input logic [31:0] ins,
                           input logic v, input logic [31:0] c);
        chk({tag, ".imem_address"}, fif.imem_address, p);
        chk({tag, ".if_pc"}, fif.if_pc, ip);
        chk({tag, ".if_instruction"}, fif.if_instruction, ins);
        chk({tag, ".if_valid"}, {31'h0, fif.if_valid}, {31'h0, v});
        chk({tag, ".fetch_count"}, fif.fetch_count, c);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ifpc = 32'h0; m_instr = 32'h0;
        m_valid = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic model_edge(input logic br, input logic frz,
                              input logic [31:0] ba);
        if (br) begin
            m_pc = ba & ~32'h3;
            m_ifpc = 0; m_instr = 0; m_valid = 0;
        end else if (!frz) begin
            m_instr = memf(m_pc);
            m_pc = m_pc + 4;
            m_ifpc = m_pc;
            m_valid = 1;
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic drive(input logic br, input logic frz,
                         input logic [31:0] ba);
        fif.branch_taken = br;
        fif.freeze = frz;
        fif.branch_address = ba;
    endtask

    typedef struct {
        logic        br;
        logic        frz;
        logic [31:0] ba;
        logic [31:0] e_pc;
        logic [31:0] e_ifpc;
        logic [31:0] e_ins;
        logic        e_v;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic br, input logic frz,
                       input logic [31:0] ba, input logic [31:0] p,
                       input logic [31:0] ip, input logic [31:0] ins,
                       input logic v, input logic [31:0] c);
        vec_t r;
        r.br = br; r.frz = frz; r.ba = ba;
        r.e_pc = p; r.e_ifpc = ip; r.e_ins = ins;
        r.e_v = v; r.e_cnt = c;
        vt.push_back(r);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        drive(0, 0, 0);

        add(0,0,0,   32'h4, 32'h4, 32'hE3A00014, 1, 1);
        add(0,0,0,   32'h8, 32'h8, 32'hE3A01A01, 1, 2);
        add(0,1,0,   32'h8, 32'h8, 32'hE3A01A01, 1, 2);
        add(0,1,0,   32'h8, 32'h8, 32'hE3A01A01, 1, 2);
        add(0,1,0,   32'h8, 32'h8, 32'hE3A01A01, 1, 2);
        add(0,0,0,   32'hC, 32'hC, memf(32'h8), 1, 3);
        add(0,0,0,   32'h10, 32'h10, memf(32'hC), 1, 4);
        add(1,0,32'h94, 32'h94, 0, 0, 0, 4);
        add(1,0,32'h70, 32'h70, 0, 0, 0, 4);
        add(0,0,0,   32'h74, 32'h74, memf(32'h70), 1, 5);
        add(1,1,32'h93, 32'h90, 0, 0, 0, 5);
        add(0,0,0,   32'h94, 32'h94, memf(32'h90), 1, 6);
        add(1,0,32'hFFFFFFFF, 32'hFFFFFFFC, 0, 0, 0, 6);
        add(0,0,0,   32'h0, 32'h0, memf(32'hFFFFFFFC), 1, 7);
        add(0,0,0,   32'h4, 32'h4, 32'hE3A00014, 1, 8);

        #12;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        chk_all("first_cycle", 0, 0, 0, 0, 0);

        foreach (vt[i]) begin
            drive(vt[i].br, vt[i].frz, vt[i].ba);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vt[i].e_pc, vt[i].e_ifpc,
                    vt[i].e_ins, vt[i].e_v, vt[i].e_cnt);
        end

        // Asynchronous reset between edges with PC=0x40 and valid set.
        drive(1, 0, 32'h3C);
        @(posedge clk); #1;
        drive(0, 0, 0);
        @(posedge clk); #1;
        chk("pre_async.imem_address", fif.imem_address, 32'h40);
        chk("pre_async.if_valid", {31'h0, fif.if_valid}, 32'h1);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);

        // Reset held across an edge with freeze and branch asserted.
        drive(1, 1, 32'h80);
        @(posedge clk); #1;
        chk_all("rst_over_branch", 0, 0, 0, 0, 0);
        rst = 1'b1;
        drive(0, 0, 0);
        @(posedge clk); #1;
        chk_all("restart", 4, 4, 32'hE3A00014, 1, 1);

        // Random traffic against the model.
        model_reset();
        model_edge(0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic        br, frz;
            logic [31:0] ba;
            br  = ($urandom_range(0, 9) == 0);
            frz = ($urandom_range(0, 3) == 0);
            ba  = ($urandom_range(0, 7) == 0)
                ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                : $urandom;
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                #1;
                model_reset();
                chk_all("rnd_rst", m_pc, m_ifpc, m_instr, m_valid, m_cnt);
                rst = 1'b1;
            end
            drive(br, frz, ba);
            @(posedge clk);
            model_edge(br, frz, ba);
            #1;
            if (n % 50 == 0 || br || frz)
                chk_all($sformatf("rnd%0d", n), m_pc, m_ifpc,
                        m_instr, m_valid, m_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
